// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_pkg;

   localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
   localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
   localparam logic [5:0] CMD_SET_BLOCKLEN  = 6'd16;
   localparam logic [5:0] CMD_READ_SINGLE   = 6'd17;
   localparam logic [5:0] ACMD_SEND_OP_COND = 6'd41;
   localparam logic [5:0] CMD_APP_CMD       = 6'd55;

   localparam logic [7:0] DATA_TOKEN   = 8'hFE;
   localparam logic [7:0] R1_IDLE      = 8'h01;
   localparam logic [7:0] R1_ILLEGAL   = 8'h04;
   localparam logic [7:0] R1_READ_IDLE = 8'h05;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_NCR,
      ST_RESP,
      ST_NAC,
      ST_TOKEN,
      ST_DATA,
      ST_CRC
   } sdState_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and flags sdClk edges.
module spi_sync_edge (
   input  logic clk,
   input  logic rstn,
   input  logic sdClk,
   input  logic sdMosi,
   input  logic sdCs,
   output logic clkRise,
   output logic clkFall,
   output logic mosiSync,
   output logic csSync
);

   logic [1:0] clkPipe;
   logic [1:0] mosiPipe;
   logic [1:0] csPipe;
   logic       clkLast;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         clkPipe  <= 2'b00;
         mosiPipe <= 2'b11;
         csPipe   <= 2'b11;
         clkLast  <= 1'b0;
      end else begin
         clkPipe  <= {clkPipe[0], sdClk};
         mosiPipe <= {mosiPipe[0], sdMosi};
         csPipe   <= {csPipe[0], sdCs};
         clkLast  <= clkPipe[1];
      end
   end

   // MOSI goes through the same depth as sdClk, so it is aligned with clkRise.
   assign clkRise  = clkPipe[1] & ~clkLast;
   assign clkFall  = ~clkPipe[1] & clkLast;
   assign mosiSync = mosiPipe[1];
   assign csSync   = csPipe[1];

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of the SD SPI link: decodes 48-bit command frames, answers R1/R7
// and streams single-block reads from an external byte memory.
module sd_spi_responder
   import sd_pkg::*;
#(
   parameter int IDLE_POLLS = 2,
   parameter int MIN_HALF   = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        sdClk,
   input  logic        sdMosi,
   input  logic        sdCs,
   output logic        sdMiso,
   output logic [8:0]  memAddr,
   input  logic [7:0]  memData,
   output logic [31:0] blockAddr,
   output logic        readStart
);

   // Edge detection takes 3 clk, so a half-period must outlast that latency.
   if (MIN_HALF < 4) begin : g_min_half_check
      $error("sd_spi_responder: MIN_HALF must be at least 4");
   end

   localparam logic [7:0] POLL_LIMIT = 8'(IDLE_POLLS);

   sdState_t    state, nextState;
   logic        clkRise, clkFall, mosiSync, csSync;
   logic [5:0]  cnt;
   logic [44:0] cmdShift;
   logic [39:0] txShift;
   logic        prevBit, respLong, readPending;
   logic        idle, appCmd;
   logic [7:0]  polls;
   logic        bitEvent, frameDone;
   logic [5:0]  cmdIdx;
   logic [31:0] cmdArg;
   logic [7:0]  idleR1;
   logic [39:0] respWord;
   logic        respIsLong, startRead, idleNext;
   logic [7:0]  pollsNext;

   spi_sync_edge u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .sdClk    (sdClk),
      .sdMosi   (sdMosi),
      .sdCs     (sdCs),
      .clkRise  (clkRise),
      .clkFall  (clkFall),
      .mosiSync (mosiSync),
      .csSync   (csSync)
   );

   // When the stop bit arrives, cmdShift holds index, argument and CRC.
   assign cmdIdx    = cmdShift[44:39];
   assign cmdArg    = cmdShift[38:7];
   assign idleR1    = {7'b0, idle};
   assign bitEvent  = (state == ST_IDLE || state == ST_CMD) ? clkRise : clkFall;
   assign frameDone = (state == ST_CMD) && clkRise && (cnt == 6'd45) && !csSync;

   always_ff @(posedge clk) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      if (csSync) begin
         nextState = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (clkRise && !prevBit && mosiSync) nextState = ST_CMD;
            ST_CMD:   if (frameDone) nextState = ST_NCR;
            ST_NCR:   if (clkFall && cnt == 6'd7) nextState = ST_RESP;
            ST_RESP:  if (clkFall && cnt == (respLong ? 6'd39 : 6'd7))
                         nextState = readPending ? ST_NAC : ST_IDLE;
            ST_NAC:   if (clkFall && cnt == 6'd7) nextState = ST_TOKEN;
            ST_TOKEN: if (clkFall && cnt == 6'd7) nextState = ST_DATA;
            ST_DATA:  if (clkFall && cnt[2:0] == 3'd7 && memAddr == 9'd511) nextState = ST_CRC;
            ST_CRC:   if (clkFall && cnt == 6'd15) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
         endcase
      end
   end

   // Response and card-state update for the frame completing this cycle.
   always_comb begin
      respWord   = {R1_ILLEGAL | idleR1, 32'hFFFF_FFFF};
      respIsLong = 1'b0;
      startRead  = 1'b0;
      idleNext   = idle;
      pollsNext  = polls;
      if (cmdIdx == ACMD_SEND_OP_COND && appCmd) begin
         if (polls < POLL_LIMIT) begin
            respWord[39:32] = R1_IDLE;
            pollsNext       = polls + 8'd1;
         end else begin
            respWord[39:32] = 8'h00;
            idleNext        = 1'b0;
         end
      end else begin
         case (cmdIdx)
            CMD_GO_IDLE: begin
               respWord[39:32] = R1_IDLE;
               idleNext        = 1'b1;
               pollsNext       = 8'd0;
            end
            CMD_SEND_IF_COND: begin
               respWord   = {idleR1, 16'h0000, 4'h0, cmdArg[11:8], cmdArg[7:0]};
               respIsLong = 1'b1;
            end
            CMD_APP_CMD, CMD_SET_BLOCKLEN: respWord[39:32] = idleR1;
            CMD_READ_SINGLE: begin
               if (idle) begin
                  respWord[39:32] = R1_READ_IDLE;
               end else begin
                  respWord[39:32] = 8'h00;
                  startRead       = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt         <= '0;
         cmdShift    <= '0;
         txShift     <= '1;
         prevBit     <= 1'b1;
         respLong    <= 1'b0;
         readPending <= 1'b0;
         idle        <= 1'b1;
         polls       <= 8'd0;
         appCmd      <= 1'b0;
         sdMiso      <= 1'b1;
         memAddr     <= 9'd0;
         blockAddr   <= 32'd0;
         readStart   <= 1'b0;
      end else begin
         readStart <= 1'b0;

         if (csSync || nextState != state) cnt <= '0;
         else if (bitEvent)                cnt <= cnt + 6'd1;

         // Only a 0 then 1 seen in IDLE may start a frame.
         if (csSync || state != ST_IDLE) prevBit <= 1'b1;
         else if (clkRise)                prevBit <= mosiSync;

         if (state == ST_CMD && clkRise) cmdShift <= {cmdShift[43:0], mosiSync};

         if (frameDone) begin
            txShift     <= respWord;
            respLong    <= respIsLong;
            readPending <= startRead;
            idle        <= idleNext;
            polls       <= pollsNext;
            appCmd      <= (cmdIdx == CMD_APP_CMD);
            if (startRead) begin
               blockAddr <= cmdArg;
               readStart <= 1'b1;
               memAddr   <= 9'd0;
            end
         end

         if (csSync) begin
            sdMiso <= 1'b1;
         end else if (clkFall) begin
            case (state)
               ST_RESP, ST_TOKEN: begin
                  sdMiso  <= txShift[39];
                  txShift <= {txShift[38:0], 1'b1};
               end
               ST_NAC: begin
                  sdMiso <= 1'b1;
                  if (cnt == 6'd7) txShift <= {DATA_TOKEN, 32'hFFFF_FFFF};
               end
               ST_DATA: begin
                  if (cnt[2:0] == 3'd0) begin
                     sdMiso  <= memData[7];
                     txShift <= {memData[6:0], 1'b1, 32'hFFFF_FFFF};
                  end else begin
                     sdMiso  <= txShift[39];
                     txShift <= {txShift[38:0], 1'b1};
                  end
                  // Advancing on the last bit leaves a full bit time for the memory read.
                  if (cnt[2:0] == 3'd7 && memAddr != 9'd511) memAddr <= memAddr + 9'd1;
               end
               default: sdMiso <= 1'b1;
            endcase
         end
      end
   end

endmodule
